// File: rtl/sprite_pkg.sv
// Shared types and constants for the sprite rendering pipeline.
package sprite_pkg;

  typedef logic [9:0] pix_coord_t;

  typedef struct packed {
    logic [3:0] red;
    logic [3:0] green;
    logic [3:0] blue;
  } rgb4_t;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int PIPE_LAT = 3;

  // Bit width able to index v entries, never narrower than one bit.
  function automatic int clog2_min1(input int v);
    return (v > 1) ? $clog2(v) : 1;
  endfunction

endpackage

// File: rtl/sprite_anim_ctrl.sv
// Per-frame control for the sprite mapper: frame-start detect, position
// latch, animation divider and frame counter.
// Optional macro MAPPER_MIRROR_EN adds a horizontal mirror bit latched with
// the position.
// The cur_* outputs forward the values being latched on the frame-start
// cycle so that pixel (0,0) already sees the new frame's settings.
module sprite_anim_ctrl
  import sprite_pkg::*;
#(
  parameter int FRAMES   = 4,
  parameter int ANIM_DIV = 8,
  parameter int FIDX_W   = 2
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  pix_coord_t        DrawX,
  input  pix_coord_t        DrawY,
  input  pix_coord_t        pos_x,
  input  pix_coord_t        pos_y,
  input  logic              anim_en,
`ifdef MAPPER_MIRROR_EN
  input  logic              mirror_x,
  output logic              cur_mirror,
`endif
  output pix_coord_t        cur_x,
  output pix_coord_t        cur_y,
  output logic [FIDX_W-1:0] cur_frame,
  output logic [FIDX_W-1:0] frame_idx
);

  localparam int DIV_W = clog2_min1(ANIM_DIV);

  pix_coord_t        lat_x;
  pix_coord_t        lat_y;
  logic [DIV_W-1:0]  div_cnt;
  logic [FIDX_W-1:0] frame_next;
  logic              frame_start;
  logic              div_wrap;
  logic              step;

  assign frame_start = (DrawX == '0) && (DrawY == '0);
  assign div_wrap    = (div_cnt == DIV_W'(ANIM_DIV - 1));
  assign step        = frame_start && anim_en && div_wrap;
  assign frame_next  = (frame_idx == FIDX_W'(FRAMES - 1)) ? '0 : frame_idx + 1'b1;

  assign cur_x     = frame_start ? pos_x : lat_x;
  assign cur_y     = frame_start ? pos_y : lat_y;
  assign cur_frame = step ? frame_next : frame_idx;

`ifdef MAPPER_MIRROR_EN
  logic lat_mirror;
  assign cur_mirror = frame_start ? mirror_x : lat_mirror;

  // Mirror bit is captured together with the position once per frame.
  always_ff @(posedge vga_clk) begin
    if (reset)            lat_mirror <= 1'b0;
    else if (frame_start) lat_mirror <= mirror_x;
  end
`endif

  // Position latch plus divider/frame counter, all advanced at frame start.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      lat_x     <= '0;
      lat_y     <= '0;
      div_cnt   <= '0;
      frame_idx <= '0;
    end else if (frame_start) begin
      lat_x <= pos_x;
      lat_y <= pos_y;
      if (anim_en) begin
        if (div_wrap) begin
          div_cnt   <= '0;
          frame_idx <= frame_next;
        end else begin
          div_cnt <= div_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/sprite_mapper_anim.sv
// Animated, integer-scaled sprite renderer: hit test, ROM addressing and a
// three-stage pipeline producing registered RGB plus an opaque flag.
// Optional macro MAPPER_MIRROR_EN adds the mirror_x input (horizontal flip).
module sprite_mapper_anim
  import sprite_pkg::*;
#(
  parameter  int SPR_W      = 16,
  parameter  int SPR_H      = 16,
  parameter  int FRAMES     = 4,
  parameter  int SCALE_LOG2 = 1,
  parameter  int IDX_W      = 3,
  parameter  int TRANSP_IDX = 0,
  parameter  int ANIM_DIV   = 8,
  localparam int ADDR_W     = clog2_min1(FRAMES * SPR_W * SPR_H),
  localparam int FIDX_W     = clog2_min1(FRAMES)
) (
  input  logic              vga_clk,
  input  logic              reset,
  input  pix_coord_t        DrawX,
  input  pix_coord_t        DrawY,
  input  logic              blank,
  input  pix_coord_t        pos_x,
  input  pix_coord_t        pos_y,
  input  logic              anim_en,
`ifdef MAPPER_MIRROR_EN
  input  logic              mirror_x,
`endif
  output logic [ADDR_W-1:0] rom_address,
  input  logic [IDX_W-1:0]  rom_q,
  output logic [IDX_W-1:0]  pal_index,
  input  logic [3:0]        palette_red,
  input  logic [3:0]        palette_green,
  input  logic [3:0]        palette_blue,
  output logic [3:0]        red,
  output logic [3:0]        green,
  output logic [3:0]        blue,
  output logic              opaque,
  output logic [FIDX_W-1:0] frame_idx
);

  localparam int TX_W = clog2_min1(SPR_W);
  localparam int TY_W = clog2_min1(SPR_H);

  pix_coord_t        cur_x;
  pix_coord_t        cur_y;
  logic [FIDX_W-1:0] cur_frame;
  logic              cur_mirror;

  sprite_anim_ctrl #(
    .FRAMES   (FRAMES),
    .ANIM_DIV (ANIM_DIV),
    .FIDX_W   (FIDX_W)
  ) u_ctrl (
    .vga_clk    (vga_clk),
    .reset      (reset),
    .DrawX      (DrawX),
    .DrawY      (DrawY),
    .pos_x      (pos_x),
    .pos_y      (pos_y),
    .anim_en    (anim_en),
`ifdef MAPPER_MIRROR_EN
    .mirror_x   (mirror_x),
    .cur_mirror (cur_mirror),
`endif
    .cur_x      (cur_x),
    .cur_y      (cur_y),
    .cur_frame  (cur_frame),
    .frame_idx  (frame_idx)
  );

`ifndef MAPPER_MIRROR_EN
  assign cur_mirror = 1'b0;
`endif

  // Hit test in 11-bit unsigned space; the >= checks stop negative offsets
  // from wrapping, and the screen bounds clip the right/bottom edges.
  logic [10:0]       dx;
  logic [10:0]       dy;
  logic              in_spr;
  logic [TX_W-1:0]   tx;
  logic [TX_W-1:0]   tx_eff;
  logic [TY_W-1:0]   ty;
  logic [ADDR_W-1:0] addr_calc;

  assign dx = {1'b0, DrawX} - {1'b0, cur_x};
  assign dy = {1'b0, DrawY} - {1'b0, cur_y};

  assign in_spr = (DrawX >= cur_x) && (dx < 11'(SPR_W << SCALE_LOG2)) &&
                  (DrawY >= cur_y) && (dy < 11'(SPR_H << SCALE_LOG2)) &&
                  (DrawX < pix_coord_t'(SCREEN_W)) && (DrawY < pix_coord_t'(SCREEN_H));

  assign tx     = TX_W'(dx >> SCALE_LOG2);
  assign ty     = TY_W'(dy >> SCALE_LOG2);
  assign tx_eff = cur_mirror ? (TX_W'(SPR_W - 1) - tx) : tx;

  assign addr_calc = ADDR_W'(cur_frame) * ADDR_W'(SPR_W * SPR_H) +
                     ADDR_W'(ty) * ADDR_W'(SPR_W) + ADDR_W'(tx_eff);

  assign pal_index = rom_q;

  rgb4_t colour;
  logic  v1;
  logic  v2;

  assign red   = colour.red;
  assign green = colour.green;
  assign blue  = colour.blue;

  // S1 address/valid, S2 valid follows ROM latency, S3 palette to output.
  always_ff @(posedge vga_clk) begin
    if (reset) begin
      rom_address <= '0;
      v1          <= 1'b0;
      v2          <= 1'b0;
      colour      <= '0;
      opaque      <= 1'b0;
    end else begin
      if (in_spr) rom_address <= addr_calc;
      v1 <= in_spr && blank;
      v2 <= v1;
      if (v2 && (rom_q != IDX_W'(TRANSP_IDX))) begin
        colour <= '{red: palette_red, green: palette_green, blue: palette_blue};
        opaque <= 1'b1;
      end else begin
        colour <= '0;
        opaque <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_sprite_mapper_anim.sv
// Directed bench for sprite_mapper_anim with a synchronous ROM model and a
// simple combinational palette. Define MAPPER_MIRROR_EN to exercise mirroring.
module tb_sprite_mapper_anim;
  import sprite_pkg::*;

  logic       vga_clk = 1'b0;
  logic       reset;
  pix_coord_t DrawX, DrawY, pos_x, pos_y;
  logic       blank, anim_en;
  logic [9:0] rom_address;
  logic [2:0] rom_q;
  logic [2:0] pal_index;
  logic [3:0] palette_red, palette_green, palette_blue;
  logic [3:0] red, green, blue;
  logic       opaque;
  logic [1:0] frame_idx;
`ifdef MAPPER_MIRROR_EN
  logic       mirror_x;
`endif

  sprite_mapper_anim dut (
    .vga_clk       (vga_clk),
    .reset         (reset),
    .DrawX         (DrawX),
    .DrawY         (DrawY),
    .blank         (blank),
    .pos_x         (pos_x),
    .pos_y         (pos_y),
    .anim_en       (anim_en),
`ifdef MAPPER_MIRROR_EN
    .mirror_x      (mirror_x),
`endif
    .rom_address   (rom_address),
    .rom_q         (rom_q),
    .pal_index     (pal_index),
    .palette_red   (palette_red),
    .palette_green (palette_green),
    .palette_blue  (palette_blue),
    .red           (red),
    .green         (green),
    .blue          (blue),
    .opaque        (opaque),
    .frame_idx     (frame_idx)
  );

  always #5 vga_clk = ~vga_clk;

  // ROM content: index = (addr % 7) + 1, with address 17 forced transparent.
  logic [2:0] rom_mem [0:1023];
  always @(posedge vga_clk) rom_q <= rom_mem[rom_address];

  assign palette_red   = {1'b0, pal_index};
  assign palette_green = {pal_index, 1'b1};
  assign palette_blue  = 4'd15 - {1'b0, pal_index};

  function automatic logic [11:0] pal_rgb(input int idx);
    logic [3:0] i4;
    i4 = 4'(idx);
    return {i4, 4'(i4 * 2 + 1), 4'(15 - i4)};
  endfunction

  int total = 0;
  int bad   = 0;
  int last_addr = 0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic idle(input int n);
    DrawX = 10'd700; DrawY = 10'd500; blank = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic frame_start();
    DrawX = 10'd0; DrawY = 10'd0; blank = 1'b0;
    tick();
    idle(1);
  endtask

  // One pixel through the pipeline: address after one edge, nothing yet
  // after two, colour/opaque after PIPE_LAT edges.
  task automatic run_pix(input string name, input int x, input int y, input bit b,
                         input bit inspr, input int addr, input bit op, input int idx);
    int exp_addr;
    logic [11:0] exp_rgb;
    idle(PIPE_LAT);
    DrawX = 10'(x); DrawY = 10'(y); blank = b;
    tick();
    exp_addr = inspr ? addr : last_addr;
    last_addr = exp_addr;
    check({name, " addr"}, int'(rom_address), exp_addr);
    DrawX = 10'd700; DrawY = 10'd500; blank = 1'b0;
    tick();
    check({name, " early"}, int'(opaque), 0);
    for (int i = 2; i < PIPE_LAT; i++) tick();
    exp_rgb = op ? pal_rgb(idx) : 12'd0;
    check({name, " opaque"}, int'(opaque), int'(op));
    check({name, " rgb"}, int'({red, green, blue}), int'(exp_rgb));
  endtask

  typedef struct {
    int x; int y; bit b; bit inspr; int addr; bit op; int idx;
  } vec_t;

  vec_t vecs [12];

  initial begin
    for (int a = 0; a < 1024; a++) rom_mem[a] = 3'((a % 7) + 1);
    rom_mem[17] = 3'd0;

    // lat=(100,50), frame 0, 2x scale -> 32x32 on screen
    vecs[0]  = '{100, 50, 1, 1,   0, 1, 1};
    vecs[1]  = '{101, 51, 1, 1,   0, 1, 1};
    vecs[2]  = '{102, 50, 1, 1,   1, 1, 2};
    vecs[3]  = '{131, 50, 1, 1,  15, 1, 2};
    vecs[4]  = '{132, 50, 1, 0,   0, 0, 0};
    vecs[5]  = '{131, 81, 1, 1, 255, 1, 4};
    vecs[6]  = '{100, 82, 1, 0,   0, 0, 0};
    vecs[7]  = '{ 99, 50, 1, 0,   0, 0, 0};
    vecs[8]  = '{100, 49, 1, 0,   0, 0, 0};
    vecs[9]  = '{110, 60, 0, 1,  85, 0, 0};
    vecs[10] = '{120, 70, 1, 1, 170, 1, 3};
    vecs[11] = '{102, 52, 1, 1,  17, 0, 0};

    reset = 1'b1; anim_en = 1'b0; pos_x = '0; pos_y = '0;
`ifdef MAPPER_MIRROR_EN
    mirror_x = 1'b0;
`endif
    idle(2);
    check("reset rom_address", int'(rom_address), 0);
    check("reset opaque", int'(opaque), 0);
    check("reset rgb", int'({red, green, blue}), 0);
    check("reset frame_idx", int'(frame_idx), 0);
    reset = 1'b0;

    pos_x = 10'd100; pos_y = 10'd50;
    frame_start();
    last_addr = 0;

    foreach (vecs[i]) begin
      $display("vec %0d: pixel (%0d,%0d) blank=%0d", i, vecs[i].x, vecs[i].y, vecs[i].b);
      run_pix($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].b,
              vecs[i].inspr, vecs[i].addr, vecs[i].op, vecs[i].idx);
    end

    // Position change mid-frame is ignored until the next frame start.
    pos_x = 10'd200;
    DrawX = 10'd5; DrawY = 10'd10; blank = 1'b1;
    tick();
    run_pix("midframe old pos", 100, 50, 1, 1, 0, 1, 1);
    run_pix("midframe new pos", 200, 50, 1, 0, 0, 0, 0);
    frame_start();
    run_pix("newframe new pos", 200, 50, 1, 1, 0, 1, 1);
    run_pix("newframe old pos", 100, 50, 1, 0, 0, 0, 0);
    pos_x = 10'd100;
    frame_start();

    // Animation: frame_idx steps every 8th frame start and wraps after 4.
    anim_en = 1'b1;
    for (int k = 1; k <= 32; k++) begin
      frame_start();
      check($sformatf("anim k=%0d frame_idx", k), int'(frame_idx), (k / 8) % 4);
      if (k == 8) begin
        run_pix("frame1 origin", 100, 50, 1, 1, 256, 1, 5);
        run_pix("frame1 corner", 131, 81, 1, 1, 511, 1, 1);
      end
    end
    anim_en = 1'b0;
    for (int k = 0; k < 10; k++) frame_start();
    check("anim hold frame_idx", int'(frame_idx), 0);
    anim_en = 1'b1;
    for (int k = 0; k < 8; k++) frame_start();
    check("anim resume frame_idx", int'(frame_idx), 1);
    anim_en = 1'b0;

    // Right-edge clipping with frame 1 selected.
    pos_x = 10'd630; pos_y = 10'd50;
    frame_start();
    run_pix("clip col630", 630, 50, 1, 1, 256, 1, 5);
    run_pix("clip col639", 639, 50, 1, 1, 260, 1, 2);
    run_pix("clip col0",     0, 51, 1, 0,   0, 0, 0);
    run_pix("clip col21",   21, 51, 1, 0,   0, 0, 0);
    run_pix("clip blanked", 635, 55, 0, 1, 290, 0, 0);

    // Reset mid-frame with a full pipeline and frame_idx=1.
    pos_x = 10'd100; pos_y = 10'd50;
    frame_start();
    DrawX = 10'd100; DrawY = 10'd50; blank = 1'b1;
    for (int i = 0; i < PIPE_LAT; i++) tick();
    check("pre-reset opaque", int'(opaque), 1);
    DrawX = 10'd100; DrawY = 10'd240; reset = 1'b1;
    tick();
    $display("reset asserted at DrawY=240");
    check("midreset opaque", int'(opaque), 0);
    check("midreset rgb", int'({red, green, blue}), 0);
    check("midreset rom_address", int'(rom_address), 0);
    check("midreset frame_idx", int'(frame_idx), 0);
    reset = 1'b0;
    last_addr = 0;
    run_pix("post-reset lat0", 10, 10, 1, 1, 85, 1, 2);

`ifdef MAPPER_MIRROR_EN
    mirror_x = 1'b1;
    pos_x = 10'd100; pos_y = 10'd50;
    frame_start();
    run_pix("mirror origin", 100, 50, 1, 1, 15, 1, 2);
    run_pix("mirror tx15", 131, 50, 1, 1, 0, 1, 1);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
